inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Decoupling FIFO between inst_fetch and decode. Captures one fetched
//  {pc, inst, pred_taken} per cycle and presents up to two oldest entries
//  per cycle to a 2-wide decode stage. Backpressure to fetch replaces a hard
//  stall. Synchronous flush on redirect (mispredict, exception).
// PARAMETERS
//  DEPTH   8   entries; power of 2, >= 4
//  XLEN    32  pc/instruction width
// PORTS
//  clock           in   1     core clock, all state on rising edge
//  reset           in   1     asynchronous, active-low reset
//  flush           in   1     sync flush; discard all entries
//  enq_valid       in   1     fetch presents an entry
//  enq_pc          in   XLEN  pc of fetched instruction
//  enq_inst        in   XLEN  instruction word from icache
//  enq_pred_taken  in   1     branch predictor decision for this pc
//  enq_ready       out  1     queue can accept an entry this cycle
//  deq_valid       out  2     [0]=oldest entry valid, [1]=second-oldest valid
//  deq_pc0/deq_pc1 out  XLEN  pc of slot 0 / slot 1
//  deq_inst0/1     out  XLEN  instruction of slot 0 / slot 1
//  deq_pred_taken  out  2     predictor bit per slot
//  deq_ready       in   2     decode accepts slot; must be a prefix (00,01,11)
//  count           out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Storage: DEPTH-entry circular array; head/tail pointers of
//    $clog2(DEPTH) bits wrap naturally; separate count register.
//  - Reset (reset==0, async): head=tail=0, count=0 -> deq_valid=2'b00,
//    enq_ready=0 while asserted, 1 from first cycle after release.
//    deq_pc*/deq_inst* are don't-care while the matching deq_valid bit is 0.
//  - enq_ready = (count != DEPTH). Depends only on registered state; a
//    same-cycle dequeue does NOT free a slot for enqueue (no full bypass).
//  - Enqueue fires when enq_valid & enq_ready; entry written at tail,
//    tail+1. Entry becomes visible on deq outputs next cycle (1-cycle
//    latency, no empty bypass).
//  - deq_valid[0] = (count>=1), deq_valid[1] = (count>=2). Slot 0 = entry
//    at head, slot 1 = entry at head+1 (mod DEPTH). Outputs are read
//    combinationally from storage.
//  - Dequeue count n = (deq_valid[0]&deq_ready[0]) +
//    (deq_valid[1]&deq_ready[1]&deq_valid[0]&deq_ready[0]). deq_ready=10
//    is illegal; block treats it as 00 (assertion fires in sim).
//  - head += n; count_next = count + enq_fire - n. Simultaneous enq+deq
//    when count==DEPTH-1 or ==1 handled without loss; order strictly FIFO.
//  - flush=1: highest priority. Next cycle head=tail=count=0; any enq or
//    deq in the flush cycle is discarded (decode must ignore slots it
//    accepted during flush). enq_ready stays at its pre-flush value in
//    the flush cycle, 1 the cycle after.
//  - Reset mid-operation: all entries lost immediately, same as reset.
//  - Assertions: count<=DEPTH; no enq when !enq_ready; no deq beyond valid.
// TESTING
//  1 Reset, enq pc 0x0..0x1C (8 entries), deq_ready=00 -> enq_ready=0 at
//    count=8; 9th enq (pc 0x20) held by fetch, not written.
//  2 Queue full, deq_ready=11 -> slots show pc 0x0/0x4 then 0x8/0xC;
//    count 8->6->4; enq_ready=1 the cycle after first dequeue.
//  3 Empty queue, enq pc 0x100 at cycle N -> deq_valid=00 at N,
//    01 at N+1 with deq_pc0=0x100; count=1 gives deq_valid=01 only.
//  4 count=3, enq + deq_ready=11 same cycle -> count=2, slot0 = 3rd-oldest
//    entry, new entry in slot1.
//  5 count=5, flush with enq_valid=1 and deq_ready=11 -> next cycle count=0,
//    deq_valid=00, enq_ready=1; following enq pc 0x200 appears as slot0.
//  6 Stream 40 entries pc 0x0,0x4,.. with random deq_ready prefixes and
//    one async reset pulse at cycle 17 -> scoreboard in-order, no
//    loss/dup across wrap; count=0, deq_valid=00 right after reset.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling FIFO: one entry in per cycle, up to two oldest
// entries presented to a 2-wide decode stage, synchronous flush on redirect.
module inst_fetch_queue #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       enq_valid,
   input  logic [XLEN-1:0]            enq_pc,
   input  logic [XLEN-1:0]            enq_inst,
   input  logic                       enq_pred_taken,
   output logic                       enq_ready,
   output logic [1:0]                 deq_valid,
   output logic [XLEN-1:0]            deq_pc0,
   output logic [XLEN-1:0]            deq_pc1,
   output logic [XLEN-1:0]            deq_inst0,
   output logic [XLEN-1:0]            deq_inst1,
   output logic [1:0]                 deq_pred_taken,
   input  logic [1:0]                 deq_ready,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] pc_mem_r   [DEPTH];
   logic [XLEN-1:0] inst_mem_r [DEPTH];
   logic [DEPTH-1:0] pred_mem_r;
   logic [AW-1:0]   head_r;
   logic [AW-1:0]   tail_r;
   logic [AW-1:0]   head1_s;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_nxt_s;
   logic            rst_done_r;
   logic            enq_fire_s;
   logic            deq0_s;
   logic            deq1_s;
   logic [1:0]      deq_n_s;

   // Handshake decode, dequeue count and read-out of the two oldest slots.
   always_comb begin
      head1_s        = head_r + AW'(1);
      // rst_done_r keeps enq_ready low until the first edge after reset release.
      enq_ready      = rst_done_r & (count_r != CW'(DEPTH));
      deq_valid[0]   = (count_r >= CW'(1));
      deq_valid[1]   = (count_r >= CW'(2));
      enq_fire_s     = enq_valid & enq_ready;
      // A slot-1 accept only counts when slot 0 is also taken (deq_ready=10 acts as 00).
      deq0_s         = deq_valid[0] & deq_ready[0];
      deq1_s         = deq0_s & deq_valid[1] & deq_ready[1];
      deq_n_s        = {1'b0, deq0_s} + {1'b0, deq1_s};
      count_nxt_s    = count_r + CW'(enq_fire_s) - CW'(deq_n_s);
      deq_pc0        = pc_mem_r[head_r];
      deq_pc1        = pc_mem_r[head1_s];
      deq_inst0      = inst_mem_r[head_r];
      deq_inst1      = inst_mem_r[head1_s];
      deq_pred_taken = {pred_mem_r[head1_s], pred_mem_r[head_r]};
      count          = count_r;
   end

   // Pointer and occupancy state; flush has priority over any enq/deq.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_r     <= '0;
         tail_r     <= '0;
         count_r    <= '0;
         rst_done_r <= 1'b0;
      end else if (flush) begin
         head_r     <= '0;
         tail_r     <= '0;
         count_r    <= '0;
         rst_done_r <= 1'b1;
      end else begin
         head_r     <= head_r + AW'(deq_n_s);
         tail_r     <= enq_fire_s ? tail_r + AW'(1) : tail_r;
         count_r    <= count_nxt_s;
         rst_done_r <= 1'b1;
      end
   end

   // Entry storage; contents need no reset since validity comes from count.
   always_ff @(posedge clock) begin
      if (enq_fire_s && !flush) begin
         pc_mem_r[tail_r]   <= enq_pc;
         inst_mem_r[tail_r] <= enq_inst;
         pred_mem_r[tail_r] <= enq_pred_taken;
      end
   end

   inst_fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
      .clock     (clock),
      .reset     (reset),
      .count     (count_r),
      .enq_valid (enq_valid),
      .enq_ready (enq_ready),
      .deq_ready (deq_ready),
      .deq_n     (deq_n_s)
   );
endmodule

// Protocol and occupancy properties for inst_fetch_queue.
module inst_fetch_queue_chk #(
   parameter int DEPTH = 8
) (
   input logic                   clock,
   input logic                   reset,
   input logic [$clog2(DEPTH):0] count,
   input logic                   enq_valid,
   input logic                   enq_ready,
   input logic [1:0]             deq_ready,
   input logic [1:0]             deq_n
);
   a_count_max: assert property (@(posedge clock) disable iff (!reset)
      count <= ($clog2(DEPTH)+1)'(DEPTH));
   a_no_enq_full: assert property (@(posedge clock) disable iff (!reset)
      !(enq_valid && enq_ready && count == ($clog2(DEPTH)+1)'(DEPTH)));
   a_deq_prefix: assert property (@(posedge clock) disable iff (!reset)
      deq_ready != 2'b10);
   a_deq_in_range: assert property (@(posedge clock) disable iff (!reset)
      ($clog2(DEPTH)+1)'(deq_n) <= count);
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a queue-based reference model
// checked every cycle plus hand-computed expectations.
module tb_inst_fetch_queue;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            flush = 1'b0;
   logic            enq_valid = 1'b0;
   logic [XLEN-1:0] enq_pc = '0;
   logic [XLEN-1:0] enq_inst = '0;
   logic            enq_pred_taken = 1'b0;
   logic            enq_ready;
   logic [1:0]      deq_valid;
   logic [XLEN-1:0] deq_pc0, deq_pc1, deq_inst0, deq_inst1;
   logic [1:0]      deq_pred_taken;
   logic [1:0]      deq_ready = 2'b00;
   logic [3:0]      count;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pt;
   } ent_t;
   ent_t mq[$];
   bit   m_done = 1'b0;

   inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
      .enq_pred_taken(enq_pred_taken), .enq_ready(enq_ready),
      .deq_valid(deq_valid), .deq_pc0(deq_pc0), .deq_pc1(deq_pc1),
      .deq_inst0(deq_inst0), .deq_inst1(deq_inst1),
      .deq_pred_taken(deq_pred_taken), .deq_ready(deq_ready), .count(count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return ~pc ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO of entries updated by the handshake rules.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_done = 1'b0;
      end else if (flush) begin
         mq.delete();
         m_done = 1'b1;
      end else begin
         bit fire;
         int n;
         fire = enq_valid && m_done && (mq.size() != DEPTH);
         n = 0;
         if (mq.size() >= 1 && deq_ready[0]) n = 1;
         if (n == 1 && mq.size() >= 2 && deq_ready[1]) n = 2;
         for (int i = 0; i < n; i++) void'(mq.pop_front());
         if (fire) mq.push_back('{pc: enq_pc, inst: enq_inst, pt: enq_pred_taken});
         m_done = 1'b1;
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clock) begin
      if (reset) begin
         check("cmp_enq_ready", 64'(enq_ready), 64'(m_done && mq.size() != DEPTH));
         check("cmp_count", 64'(count), 64'(mq.size()));
         check("cmp_deq_valid", 64'(deq_valid), 64'({mq.size() >= 2, mq.size() >= 1}));
         if (mq.size() >= 1) begin
            check("cmp_slot0", {deq_inst0, deq_pc0}, {mq[0].inst, mq[0].pc});
            check("cmp_pt0", 64'(deq_pred_taken[0]), 64'(mq[0].pt));
         end
         if (mq.size() >= 2) begin
            check("cmp_slot1", {deq_inst1, deq_pc1}, {mq[1].inst, mq[1].pc});
            check("cmp_pt1", 64'(deq_pred_taken[1]), 64'(mq[1].pt));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_enq(input logic v, input logic [31:0] pc);
      enq_valid      = v;
      enq_pc         = pc;
      enq_inst       = mk_inst(pc);
      enq_pred_taken = pc[3];
   endtask

   task automatic enq1(input logic [31:0] pc);
      set_enq(1'b1, pc);
      tick();
      set_enq(1'b0, 32'h0);
   endtask

   initial begin
      int sent;
      int cyc;
      logic [31:0] next_pc;
      logic was_ready;
      logic [1:0] pick;

      // 1: reset, fill to full, ninth entry held off
      #3;
      check("rst_enq_ready", 64'(enq_ready), 64'd0);
      check("rst_deq_valid", 64'(deq_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      tick();
      reset = 1'b1;
      tick();
      check("ready_after_rst", 64'(enq_ready), 64'd1);
      for (int i = 0; i < 8; i++) enq1(32'(i * 4));
      check("full_count", 64'(count), 64'd8);
      check("full_enq_ready", 64'(enq_ready), 64'd0);
      set_enq(1'b1, 32'h20);
      tick();
      check("held_count", 64'(count), 64'd8);
      check("held_pc0", 64'(deq_pc0), 64'h0);
      set_enq(1'b0, 32'h0);

      // 2: dequeue pairs from full
      deq_ready = 2'b11;
      check("t2_pc0_a", 64'(deq_pc0), 64'h0);
      check("t2_pc1_a", 64'(deq_pc1), 64'h4);
      tick();
      check("t2_count6", 64'(count), 64'd6);
      check("t2_pc0_b", 64'(deq_pc0), 64'h8);
      check("t2_pc1_b", 64'(deq_pc1), 64'hC);
      check("t2_ready", 64'(enq_ready), 64'd1);
      tick();
      check("t2_count4", 64'(count), 64'd4);

      // 3: drain, then single entry with 1-cycle latency
      tick();
      tick();
      deq_ready = 2'b00;
      check("t3_empty", 64'(deq_valid), 64'd0);
      enq1(32'h100);
      check("t3_valid01", 64'(deq_valid), 64'b01);
      check("t3_pc0", 64'(deq_pc0), 64'h100);
      check("t3_inst0", 64'(deq_inst0), 64'(mk_inst(32'h100)));

      // 4: count=3, simultaneous enq and double deq
      enq1(32'h104);
      enq1(32'h108);
      check("t4_count3", 64'(count), 64'd3);
      deq_ready = 2'b11;
      enq1(32'h10C);
      deq_ready = 2'b00;
      check("t4_count2", 64'(count), 64'd2);
      check("t4_pc0", 64'(deq_pc0), 64'h108);
      check("t4_pc1", 64'(deq_pc1), 64'h10C);

      // 5: flush at count=5 with enq and deq active
      enq1(32'h110);
      enq1(32'h114);
      enq1(32'h118);
      check("t5_count5", 64'(count), 64'd5);
      flush = 1'b1;
      deq_ready = 2'b11;
      set_enq(1'b1, 32'h1F0);
      check("t5_ready_in_flush", 64'(enq_ready), 64'd1);
      tick();
      flush = 1'b0;
      deq_ready = 2'b00;
      set_enq(1'b0, 32'h0);
      check("t5_count0", 64'(count), 64'd0);
      check("t5_valid00", 64'(deq_valid), 64'd0);
      check("t5_ready", 64'(enq_ready), 64'd1);
      enq1(32'h200);
      check("t5_pc0", 64'(deq_pc0), 64'h200);

      // flush while full: enq_ready stays low in the flush cycle
      for (int i = 1; i < 8; i++) enq1(32'h200 + 32'(i * 4));
      check("t5f_count8", 64'(count), 64'd8);
      flush = 1'b1;
      check("t5f_ready_in_flush", 64'(enq_ready), 64'd0);
      tick();
      flush = 1'b0;
      check("t5f_ready_after", 64'(enq_ready), 64'd1);
      check("t5f_count0", 64'(count), 64'd0);

      // 6: streaming with random prefixes and an async reset pulse
      sent = 0;
      next_pc = 32'h0;
      for (cyc = 0; cyc < 400 && (sent < 40 || count != 4'd0); cyc++) begin
         set_enq(sent < 40, next_pc);
         pick = 2'($urandom_range(0, 2));
         deq_ready = (pick == 2'd0) ? 2'b00 : (pick == 2'd1) ? 2'b01 : 2'b11;
         was_ready = enq_ready;
         tick();
         if (enq_valid && was_ready) begin
            sent++;
            next_pc = next_pc + 32'h4;
         end
         if (cyc == 17) begin
            #1;
            reset = 1'b0;
            #1;
            check("t6_rst_count", 64'(count), 64'd0);
            check("t6_rst_valid", 64'(deq_valid), 64'd0);
            check("t6_rst_ready", 64'(enq_ready), 64'd0);
            #1;
            reset = 1'b1;
         end
      end
      set_enq(1'b0, 32'h0);
      deq_ready = 2'b00;
      check("t6_all_sent", 64'(sent), 64'd40);
      check("t6_drained", 64'(count), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
